// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: frame layout, field codes, completion status codes
// and the command sequencer's state encoding.
package mdio_pkg;

    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_TIMEOUT = 2'b01;
    localparam logic [1:0] RSP_ILLEGAL = 2'b10;

    // Field positions: [31:30]ST [29:28]OP [27:23]PHYAD [22:18]REGAD [17:16]TA [15:0]DATA
    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phyad;
        logic [4:0]  regad;
        logic [1:0]  ta;
        logic [15:0] data;
    } mdio_frame_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CHECK = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } seq_state_t;

    function automatic logic frame_legal(input mdio_frame_t f);
        return (f.st == ST_START) && ((f.op == OP_WRITE) || (f.op == OP_READ));
    endfunction

    function automatic logic frame_is_read(input mdio_frame_t f);
        return f.op == OP_READ;
    endfunction

endpackage

// File: rtl/mdio_cmd_fifo.sv
// Command FIFO for the MDIO sequencer: DEPTH x WIDTH storage with wrap-bit
// pointers; head entry is presented combinationally on pop_data.
module mdio_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; only the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mdio_cmd_seq.sv
// Host-side MDIO command sequencer: queues frames, runs one transaction at a
// time against the mdio engine and returns a status/read-data record.
module mdio_cmd_seq
    import mdio_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [31:0]             cmd_data,
    output logic [31:0]             t_data,
    output logic                    mdio_start,
    output logic                    activado,
    input  logic                    mdio_done,
    input  logic [15:0]             mdio_rd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_status,
    output logic                    rsp_rd,
    output logic [15:0]             rsp_data,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    localparam int             TW         = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    seq_state_t     state, state_nxt;
    logic [TW-1:0]  timer;
    logic           done_q;
    logic           resp_gap;
    logic           fifo_full, fifo_empty, pop;
    logic [31:0]    head;
    logic           done_edge;
    logic           rec_load;
    logic [1:0]     rec_status;
    logic [15:0]    rec_data;

    mdio_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid && cmd_ready),
        .push_data (cmd_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign cmd_ready = !fifo_full;
    assign done_edge = mdio_done && !done_q;
    assign activado  = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        mdio_start = 1'b0;
        rec_load   = 1'b0;
        rec_status = RSP_OK;
        rec_data   = '0;
        case (state)
            S_IDLE: begin
                // The cycle after a handshake is skipped so back-to-back starts are spaced out.
                if (!fifo_empty && !resp_gap) begin
                    pop       = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!frame_legal(mdio_frame_t'(t_data))) begin
                    rec_load   = 1'b1;
                    rec_status = RSP_ILLEGAL;
                    state_nxt  = S_RESP;
                end else begin
                    mdio_start = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_edge) begin
                    rec_load   = 1'b1;
                    rec_status = RSP_OK;
                    rec_data   = frame_is_read(mdio_frame_t'(t_data)) ? mdio_rd_data : 16'h0000;
                    state_nxt  = S_RESP;
                end else if (timer == TIMER_LAST) begin
                    rec_load   = 1'b1;
                    rec_status = RSP_TIMEOUT;
                    state_nxt  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            t_data     <= '0;
            timer      <= '0;
            done_q     <= 1'b0;
            resp_gap   <= 1'b0;
            rsp_status <= RSP_OK;
            rsp_rd     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state    <= state_nxt;
            done_q   <= mdio_done;
            resp_gap <= (state == S_RESP) && rsp_ready;
            if (pop)
                t_data <= head;
            if (state == S_CHECK)
                timer <= '0;
            else if (state == S_WAIT)
                timer <= timer + TW'(1);
            if (rec_load) begin
                rsp_status <= rec_status;
                rsp_rd     <= frame_is_read(mdio_frame_t'(t_data));
                rsp_data   <= rec_data;
            end
        end
    end

endmodule
